// File: rtl/miriscv_data_arbiter.sv
// Two-requester round-robin arbiter onto a single-outstanding data memory port.
// Grants in IDLE, issues one request cycle, then waits for a response or a timeout.
module miriscv_data_arbiter #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              arstn_i,

  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [XLEN/8-1:0] m0_be_i,
  input  logic [XLEN-1:0]   m0_addr_i,
  input  logic [XLEN-1:0]   m0_wdata_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  output logic [XLEN-1:0]   m0_rdata_o,
  output logic              m0_err_o,

  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [XLEN/8-1:0] m1_be_i,
  input  logic [XLEN-1:0]   m1_addr_i,
  input  logic [XLEN-1:0]   m1_wdata_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [XLEN-1:0]   m1_rdata_o,
  output logic              m1_err_o,

  output logic              data_req_o,
  output logic              data_we_o,
  output logic [XLEN/8-1:0] data_be_o,
  output logic [XLEN-1:0]   data_addr_o,
  output logic [XLEN-1:0]   data_wdata_o,
  input  logic              data_rvalid_i,
  input  logic [XLEN-1:0]   data_rdata_i,

  output logic              spurious_o
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              we_q, we_d;
  logic [XLEN/8-1:0] be_q, be_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [7:0]        cnt_q, cnt_d;

  logic sel;
  logic gnt_en;
  logic complete;
  logic timed_out;
  logic issuing;

  // On a tie the requester that did not win last time is chosen.
  always_comb begin
    sel    = (m0_req_i && m1_req_i) ? ~last_q : m1_req_i;
    gnt_en = (state_q == StIdle) && (m0_req_i || m1_req_i) && arstn_i;
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    we_d      = we_q;
    be_d      = be_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    complete  = 1'b0;
    timed_out = 1'b0;
    case (state_q)
      StIdle: begin
        if (gnt_en) begin
          state_d = StIssue;
          owner_d = sel;
          last_d  = sel;
          we_d    = sel ? m1_we_i    : m0_we_i;
          be_d    = sel ? m1_be_i    : m0_be_i;
          addr_d  = sel ? m1_addr_i  : m0_addr_i;
          wdata_d = sel ? m1_wdata_i : m0_wdata_i;
        end
      end
      StIssue: begin
        state_d = StWait;
        cnt_d   = 8'd0;
      end
      StWait: begin
        // A response arriving on the timeout cycle still completes normally.
        if (data_rvalid_i) begin
          complete = 1'b1;
          state_d  = StIdle;
        end else if (cnt_q == CntLast) begin
          complete  = 1'b1;
          timed_out = 1'b1;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    issuing      = (state_q == StIssue);
    m0_gnt_o     = gnt_en & ~sel;
    m1_gnt_o     = gnt_en & sel;
    m0_rvalid_o  = complete & ~owner_q;
    m1_rvalid_o  = complete & owner_q;
    m0_err_o     = complete & timed_out & ~owner_q;
    m1_err_o     = complete & timed_out & owner_q;
    m0_rdata_o   = (complete && !timed_out && !owner_q) ? data_rdata_i : '0;
    m1_rdata_o   = (complete && !timed_out && owner_q) ? data_rdata_i : '0;
    data_req_o   = issuing;
    data_we_o    = issuing & we_q;
    data_be_o    = issuing ? be_q : '0;
    data_addr_o  = issuing ? addr_q : '0;
    data_wdata_o = issuing ? wdata_q : '0;
    spurious_o   = data_rvalid_i && arstn_i && (state_q != StWait);
  end

endmodule

// File: doc/miriscv_data_arbiter.md
MIRISCV_DATA_ARBITER -- requirements
Module: miriscv_data_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width.
REQ-002 SHALL have parameter TIMEOUT, default 16, max WAIT cycles before error completion; legal range 2..255.
REQ-003 SHALL have clk_i  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have arstn_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have mN_req_i  input  1  requester N (N=0,1) transaction request; held until mN_gnt_o.
REQ-006 SHALL have mN_we_i  input  1  requester N write enable.
REQ-007 SHALL have mN_be_i  input  XLEN/8  requester N byte enables.
REQ-008 SHALL have mN_addr_i  input  XLEN  requester N address.
REQ-009 SHALL have mN_wdata_i  input  XLEN  requester N write data.
REQ-010 SHALL have mN_gnt_o  output  1  one-cycle accept pulse to requester N.
REQ-011 SHALL have mN_rvalid_o  output  1  one-cycle completion pulse to requester N.
REQ-012 SHALL have mN_rdata_o  output  XLEN  response data to requester N.
REQ-013 SHALL have mN_err_o  output  1  qualifies mN_rvalid_o: completion by timeout.
REQ-014 SHALL have data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o  output  1/1/XLEN/8/XLEN/XLEN  memory request bus.
REQ-015 SHALL have data_rvalid_i  input  1 and data_rdata_i  input  XLEN  memory response.
REQ-016 SHALL have spurious_o  output  1  pulse: data_rvalid_i seen outside WAIT.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT; at most one transaction outstanding.
REQ-018 IDLE: any mN_req_i high -> select owner, pulse owner's mN_gnt_o combinationally same cycle, latch we/be/addr/wdata and owner id, go ISSUE.
REQ-019 Arbitration SHALL be round-robin: single requester wins; both requesting -> requester not in last_grant wins; last_grant updated on every grant.
REQ-020 ISSUE: data_req_o=1 for exactly one cycle with latched fields; go WAIT; request-to-memory latency = 1 cycle after grant.
REQ-021 data_we_o/be_o/addr_o/wdata_o SHALL be zero whenever data_req_o=0.
REQ-022 WAIT: data_rvalid_i=1 -> owner's mN_rvalid_o=1 same cycle, mN_rdata_o=data_rdata_i, mN_err_o=0, go IDLE.
REQ-023 WAIT SHALL count cycles from 0; count reaching TIMEOUT-1 with data_rvalid_i=0 -> owner's mN_rvalid_o=1, mN_err_o=1, mN_rdata_o=0, go IDLE.
REQ-024 data_rvalid_i and timeout in same cycle -> normal completion (err 0) wins.
REQ-025 Non-owner rvalid_o/err_o SHALL be 0; all rdata_o SHALL be 0 except owner's during completion.
REQ-026 data_rvalid_i in IDLE or ISSUE SHALL be ignored for completion and pulse spurious_o the same cycle.
REQ-027 No grant SHALL be given in ISSUE or WAIT; a new grant earliest in the cycle after completion (back-to-back throughput: one transaction per 3 cycles at 1-cycle memory latency).
REQ-028 Requester deasserting mN_req_i before grant SHALL be legal and cause no transaction.

Reset
REQ-029 On arstn_i low, SHALL asynchronously enter IDLE, clear latched fields and counter, set last_grant=1 (m0 wins first tie).
REQ-030 During and after reset all outputs SHALL be 0 until first grant.
REQ-031 Reset asserted in ISSUE or WAIT SHALL abandon the transaction with no rvalid_o to any requester; late data_rvalid_i after reset pulses spurious_o.

Verification
REQ-032 m0 write addr 0x100, wdata 0xDEADBEEF, be 0xF; memory rvalid 2 cycles after data_req_o -> m0_gnt_o cycle 0, data_req_o cycle 1 with those fields, m0_rvalid_o cycle 3, err 0.
REQ-033 m0 and m1 request continuously from reset -> grants alternate m0, m1, m0, m1; no two data_req_o closer than 3 cycles.
REQ-034 m1 read addr 0x40, memory never responds, TIMEOUT=16 -> m1_rvalid_o=1, m1_err_o=1, m1_rdata_o=0 on 16th WAIT cycle; FSM returns IDLE.
REQ-035 data_rvalid_i on exact timeout cycle with rdata 0x1234 -> m1_rvalid_o=1, err 0, rdata 0x1234.
REQ-036 data_rvalid_i in IDLE -> spurious_o=1 one cycle, no mN_rvalid_o.
REQ-037 arstn_i asserted in WAIT -> all outputs 0, next simultaneous m0/m1 request grants m0.
